// File: rtl/audio_out_ctrl.sv
// audio_out_ctrl: system-clock sequencer for the I2S sample sender.
// Start/stop control, upstream word fetch into a FIFO, one word per sender tick.
module audio_out_ctrl #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_start,
    input  logic             cmd_stop,
    input  logic             cfg_22k,
    output logic             up_req,
    input  logic             up_valid,
    input  logic [31:0]      up_data,
    output logic             snd_start,
    output logic             snd_end,
    output logic             snd_22k,
    output logic             snd_valid,
    output logic [31:0]      snd_data,
    input  logic             snd_req_tick,
    input  logic             snd_req_mode,
    output logic             busy,
    output logic             underrun,
    output logic [CNT_W-1:0] underrun_cnt
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    state_t            state_q, state_d;
    logic [31:0]       mem_q [DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              up_req_q, up_req_d;
    logic              tick_q, tick_d;
    logic              snd_start_q, snd_start_d;
    logic              snd_end_q, snd_end_d;
    logic              snd_22k_q, snd_22k_d;
    logic              snd_valid_q, snd_valid_d;
    logic [31:0]       snd_data_q, snd_data_d;
    logic              underrun_q, underrun_d;
    logic [CNT_W-1:0]  ucnt_q, ucnt_d;

    logic start_ok;
    logic req_evt;
    logic push;
    logic pop;
    logic fifo_empty;

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        up_req_d    = up_req_q;
        tick_d      = snd_req_tick;
        snd_start_d = 1'b0;
        snd_end_d   = 1'b0;
        snd_22k_d   = snd_22k_q;
        snd_valid_d = 1'b0;
        snd_data_d  = snd_data_q;
        underrun_d  = underrun_q;
        ucnt_d      = ucnt_q;

        fifo_empty = (count_q == '0);
        start_ok   = cmd_start & ~cmd_stop;
        req_evt    = snd_req_tick & ~tick_q & snd_req_mode
                   & (state_q != IDLE);
        push       = up_req_q & up_valid;
        pop        = req_evt & ~fifo_empty;

        unique case (state_q)
            IDLE: begin
                if (start_ok) begin
                    state_d     = RUN;
                    snd_start_d = 1'b1;
                    snd_22k_d   = cfg_22k;
                end
            end
            RUN: begin
                if (cmd_stop) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (fifo_empty && !up_req_q) begin
                    state_d   = IDLE;
                    snd_end_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Single outstanding request; new ones only while running.
        if (up_req_q) begin
            up_req_d = ~up_valid;
        end else begin
            up_req_d = (state_q == RUN) && (count_q < CW'(DEPTH));
        end

        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end

        if (pop) begin
            snd_valid_d = 1'b1;
            snd_data_d  = mem_q[rd_ptr_q];
            rd_ptr_d    = rd_ptr_q + PW'(1);
        end else if (req_evt && state_q == RUN) begin
            snd_valid_d = 1'b1;
            snd_data_d  = '0;
            underrun_d  = 1'b1;
            if (ucnt_q != '1) begin
                ucnt_d = ucnt_q + CNT_W'(1);
            end
        end

        count_d = count_q + CW'(push) - CW'(pop);

        if (state_q == IDLE && start_ok) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            underrun_d = 1'b0;
            ucnt_d     = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            up_req_q    <= 1'b0;
            tick_q      <= 1'b0;
            snd_start_q <= 1'b0;
            snd_end_q   <= 1'b0;
            snd_22k_q   <= 1'b0;
            snd_valid_q <= 1'b0;
            snd_data_q  <= '0;
            underrun_q  <= 1'b0;
            ucnt_q      <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            up_req_q    <= up_req_d;
            tick_q      <= tick_d;
            snd_start_q <= snd_start_d;
            snd_end_q   <= snd_end_d;
            snd_22k_q   <= snd_22k_d;
            snd_valid_q <= snd_valid_d;
            snd_data_q  <= snd_data_d;
            underrun_q  <= underrun_d;
            ucnt_q      <= ucnt_d;
        end
    end

    // Storage needs no reset; occupancy is tracked by count_q.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= up_data;
        end
    end

    assign up_req       = up_req_q;
    assign snd_start    = snd_start_q;
    assign snd_end      = snd_end_q;
    assign snd_22k      = snd_22k_q;
    assign snd_valid    = snd_valid_q;
    assign snd_data     = snd_data_q;
    assign busy         = (state_q != IDLE);
    assign underrun     = underrun_q;
    assign underrun_cnt = ucnt_q;

endmodule

// File: tb/tb_audio_out_ctrl.sv
// tb_audio_out_ctrl: directed sequence with random sample data,
// checked against a queue-based playback model.
module tb_audio_out_ctrl;

    localparam int DEPTH = 4;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             cmd_start = 1'b0;
    logic             cmd_stop = 1'b0;
    logic             cfg_22k = 1'b0;
    logic             up_valid = 1'b0;
    logic [31:0]      up_data = '0;
    logic             snd_req_tick = 1'b0;
    logic             snd_req_mode = 1'b0;
    logic             up_req;
    logic             snd_start;
    logic             snd_end;
    logic             snd_22k;
    logic             snd_valid;
    logic [31:0]      snd_data;
    logic             busy;
    logic             underrun;
    logic [CNT_W-1:0] underrun_cnt;

    audio_out_ctrl #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd_start    (cmd_start),
        .cmd_stop     (cmd_stop),
        .cfg_22k      (cfg_22k),
        .up_req       (up_req),
        .up_valid     (up_valid),
        .up_data      (up_data),
        .snd_start    (snd_start),
        .snd_end      (snd_end),
        .snd_22k      (snd_22k),
        .snd_valid    (snd_valid),
        .snd_data     (snd_data),
        .snd_req_tick (snd_req_tick),
        .snd_req_mode (snd_req_mode),
        .busy         (busy),
        .underrun     (underrun),
        .underrun_cnt (underrun_cnt)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errs = 0;
    int start_cnt = 0;
    int end_cnt = 0;
    int valid_cnt = 0;

    // Pulse counters sampled mid-cycle.
    always @(negedge clk) begin
        start_cnt = start_cnt + int'(snd_start);
        end_cnt   = end_cnt + int'(snd_end);
        valid_cnt = valid_cnt + int'(snd_valid);
    end

    typedef enum int {M_IDLE, M_RUN, M_DRAIN} mstate_t;
    mstate_t     mstate = M_IDLE;
    logic [31:0] q[$];
    int          m_under = 0;
    logic [31:0] last_data = '0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_ucnt();
        return (m_under > 255) ? 32'd255 : 32'(m_under);
    endfunction

    task automatic chk_zero(input string tag);
        chk({tag, "_up_req"}, up_req, 0);
        chk({tag, "_snd_start"}, snd_start, 0);
        chk({tag, "_snd_end"}, snd_end, 0);
        chk({tag, "_snd_22k"}, snd_22k, 0);
        chk({tag, "_snd_valid"}, snd_valid, 0);
        chk({tag, "_snd_data"}, snd_data, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_underrun"}, underrun, 0);
        chk({tag, "_ucnt"}, underrun_cnt, 0);
    endtask

    task automatic wait_req(input string tag);
        int n = 0;
        while (up_req !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk(tag, up_req, 1);
    endtask

    task automatic serve(input logic [31:0] w);
        wait_req("up_req_rise");
        if (up_req === 1'b1) begin
            repeat ($urandom_range(2, 0)) begin
                tick();
                chk("up_req_hold", up_req, 1);
            end
            assert (q.size() < DEPTH) else begin
                errs++;
                $error("FAIL fifo_overflow: observed %0d expected <%0d",
                       q.size() + 1, DEPTH + 1);
            end
            up_valid = 1'b1;
            up_data  = w;
            tick();
            up_valid = 1'b0;
            up_data  = $urandom;
            q.push_back(w);
            chk("up_req_fall", up_req, 0);
        end
    endtask

    task automatic send_tick(input bit mode, input int hold);
        logic [31:0] ed;
        bit          ev;
        int          v0;
        ev = 1'b0;
        ed = '0;
        if (mode && mstate != M_IDLE) begin
            if (q.size() > 0) begin
                ev = 1'b1;
                ed = q.pop_front();
            end else if (mstate == M_RUN) begin
                ev = 1'b1;
                m_under++;
            end
        end
        v0 = valid_cnt;
        snd_req_tick = 1'b1;
        snd_req_mode = mode;
        tick();
        chk("snd_valid", snd_valid, 32'(ev));
        chk(ev ? "snd_data" : "snd_data_hold", snd_data,
            ev ? ed : last_data);
        if (ev) last_data = ed;
        repeat (hold - 1) tick();
        snd_req_tick = 1'b0;
        tick();
        chk("one_strobe", 32'(valid_cnt - v0), 32'(ev));
        chk("underrun_cnt", underrun_cnt, exp_ucnt());
        chk("underrun", underrun, 32'(m_under > 0));
    endtask

    task automatic do_start(input bit cfg);
        int s0;
        s0 = start_cnt;
        cfg_22k   = cfg;
        cmd_start = 1'b1;
        tick();
        cmd_start = 1'b0;
        chk("snd_start", snd_start, 1);
        chk("snd_22k", snd_22k, 32'(cfg));
        chk("busy_run", busy, 1);
        chk("underrun_clr", underrun, 0);
        chk("ucnt_clr", underrun_cnt, 0);
        tick();
        chk("start_once", 32'(start_cnt - s0), 1);
        mstate  = M_RUN;
        m_under = 0;
        q.delete();
    endtask

    task automatic chk_drain_end(input int e0, input bit cfg);
        tick();
        chk("snd_end_once", 32'(end_cnt - e0), 1);
        chk("busy_idle", busy, 0);
        chk("snd_22k_kept", snd_22k, 32'(cfg));
        mstate = M_IDLE;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int e0;
        int s0;
        int v0;
        int lo;

        repeat (2) tick();
        chk_zero("reset");
        rst_n = 1'b1;
        tick();

        // Start in 22 kHz mode, prefill to full.
        do_start(1'b1);
        serve(32'hD9999991);
        serve(32'h99999993);
        serve($urandom);
        serve($urandom);
        repeat (3) begin
            tick();
            chk("no_req_full", up_req, 0);
        end
        up_valid = 1'b1;
        up_data  = 32'hDEADBEEF;
        tick();
        up_valid = 1'b0;

        send_tick(1'b1, 1);
        send_tick(1'b1, 1);
        send_tick(1'b0, 1);
        send_tick(1'b0, 2);
        serve($urandom);
        serve($urandom);

        // Held tick must give a single strobe.
        send_tick(1'b1, 3);
        send_tick(1'b1, 2);
        send_tick(1'b1, 1);
        send_tick(1'b1, 1);

        // Upstream stalled, FIFO empty: silence and underrun.
        for (int i = 0; i < 3; i++) begin
            send_tick(1'b1, 1 + (i % 2));
        end
        chk("ucnt_three", underrun_cnt, 3);

        // Two queued, one outstanding, then stop.
        serve($urandom);
        serve($urandom);
        wait_req("req_outstanding");
        e0 = end_cnt;
        cmd_stop = 1'b1;
        tick();
        cmd_stop = 1'b0;
        mstate = M_DRAIN;
        chk("busy_drain", busy, 1);
        serve($urandom);
        lo = 0;
        repeat (4) begin
            tick();
            lo += int'(up_req);
        end
        chk("no_req_drain", 32'(lo), 0);
        chk("no_end_early", 32'(end_cnt - e0), 0);
        send_tick(1'b1, 1);
        send_tick(1'b1, 2);
        send_tick(1'b1, 1);
        chk_drain_end(e0, 1'b1);

        // Start and stop together in IDLE, then stop alone.
        s0 = start_cnt;
        cmd_start = 1'b1;
        cmd_stop  = 1'b1;
        cfg_22k   = 1'b0;
        tick();
        cmd_start = 1'b0;
        tick();
        cmd_stop = 1'b0;
        tick();
        chk("idle_both_busy", busy, 0);
        chk("idle_both_start", 32'(start_cnt - s0), 0);
        chk("idle_22k_kept", snd_22k, 1);
        chk("idle_ucnt_kept", underrun_cnt, 3);

        // New start clears underrun state; both in RUN gives DRAIN.
        do_start(1'b0);
        e0 = end_cnt;
        s0 = start_cnt;
        cmd_start = 1'b1;
        cmd_stop  = 1'b1;
        tick();
        cmd_start = 1'b0;
        cmd_stop  = 1'b0;
        mstate = M_DRAIN;
        chk("run_both_busy", busy, 1);
        chk("run_both_req", up_req, 1);
        send_tick(1'b1, 1);
        serve($urandom);
        send_tick(1'b1, 1);
        chk("run_both_nostart", 32'(start_cnt - s0), 0);
        chk_drain_end(e0, 1'b0);

        // Reset mid-RUN with three words queued.
        do_start(1'($urandom));
        serve($urandom);
        serve($urandom);
        serve($urandom);
        e0 = end_cnt;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk_zero("midrun_rst");
        q.delete();
        mstate    = M_IDLE;
        m_under   = 0;
        last_data = '0;
        tick();
        v0 = valid_cnt;
        send_tick(1'b1, 1);
        tick();
        chk("rst_no_valid", 32'(valid_cnt - v0), 0);
        chk("rst_no_end", 32'(end_cnt - e0), 0);
        chk("rst_idle", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule

// File: doc/audio_out_ctrl.md
Name: audio_out_ctrl

Overview:
Sequences the I2S sample sender on the system-clock side of the NeXT ASIC audio path. Turns start/stop commands from the ASIC command decoder into sender start/end pulses and latches the 22 kHz mode. Fetches 32-bit stereo sample words from the upstream monitor-bus interface into a small FIFO. Answers each sender request tick with exactly one sample word, inserting silence on underrun.

Parameters:
DEPTH, 4, FIFO depth in 32-bit words (power of two, 2..16)
CNT_W, 8, width of saturating underrun counter

Ports:
clk  in  1  system clock (sender in_clk domain)
rst_n  in  1  synchronous active-low reset
cmd_start  in  1  one-cycle pulse: begin playback
cmd_stop  in  1  one-cycle pulse: end playback after drain
cfg_22k  in  1  mode select, sampled on accepted cmd_start
up_req  out  1  level request for one sample word upstream
up_valid  in  1  one-cycle pulse: up_data valid, completes up_req
up_data  in  32  sample word {left16, right16}
snd_start  out  1  one-cycle start pulse to sender
snd_end  out  1  one-cycle end pulse to sender
snd_22k  out  1  latched mode to sender
snd_valid  out  1  one-cycle sample strobe to sender
snd_data  out  32  sample word, valid with snd_valid
snd_req_tick  in  1  sender request tick (may span several clk cycles)
snd_req_mode  in  1  sender request-mode flag; tick counts only when high
busy  out  1  high in any state other than IDLE
underrun  out  1  sticky underrun flag, cleared on accepted cmd_start
underrun_cnt  out  CNT_W  saturating count of underruns since last start

Behaviour:
- Reset (rst_n low at clk edge): state IDLE, FIFO empty, no request outstanding; all outputs 0, including snd_22k, underrun and underrun_cnt. Reset mid-playback aborts silently, with no snd_end.
- States: IDLE, RUN, DRAIN.
- IDLE:
  - cmd_start=1 with cmd_stop=0 gives an accepted start. Next cycle: snd_start=1 for one cycle, snd_22k<=cfg_22k, FIFO flushed, underrun/underrun_cnt cleared, state RUN.
  - cmd_start and cmd_stop together in IDLE: both ignored.
  - cmd_stop alone: ignored.
- RUN:
  - cmd_start is ignored.
  - cmd_stop moves the state to DRAIN next cycle; stop wins over a simultaneous start.
- Upstream handshake:
  - At most one outstanding request.
  - up_req rises the cycle after (fifo_count < DEPTH, state RUN, none outstanding).
  - up_req holds high until the cycle up_valid=1. On that cycle up_data is pushed and up_req falls next cycle.
  - up_valid with no outstanding request is ignored.
  - An outstanding request still completes in DRAIN and its word is pushed. No new request issues in DRAIN or IDLE.
- Sender tick:
  - tick_q registers snd_req_tick.
  - A request event is snd_req_tick & ~tick_q & snd_req_mode, in RUN or DRAIN. Event at cycle N gives snd_valid=1 at cycle N+1 for exactly one cycle.
  - In RUN, FIFO non-empty: pop the head word onto snd_data.
  - In RUN, FIFO empty: snd_data=0 (silence), underrun<=1, underrun_cnt+1 saturating at all-ones.
  - In DRAIN, FIFO non-empty: pop as in RUN.
  - In DRAIN, FIFO empty: no snd_valid and no underrun.
  - A tick held high for several cycles gives one event. snd_data holds its last value when snd_valid=0.
- Drain completion: in DRAIN with FIFO empty and no outstanding request, snd_end=1 for one cycle next cycle, then state IDLE. snd_22k keeps its value.
- FIFO:
  - Circular buffer with wrapping pointers and a count of 0..DEPTH.
  - Push and pop in the same cycle leave the count unchanged; this is legal only when count>0 before the pop.
  - Push on full cannot occur by construction.
  - The bench asserts no overflow and no underflow.
- Ordering: words reach the sender in upstream arrival order, with no loss or duplication.

Test Plan:
- Reset then cmd_start with cfg_22k=1 -> snd_start pulse 1 cycle later, snd_22k=1, busy=1. up_req issues until the FIFO holds 4 words, with 4 separate handshakes.
- Prefill 0xD9999991, 0x99999993, then two tick rising edges with snd_req_mode=1 -> snd_valid one cycle after each edge carrying those words in order. Ticks with snd_req_mode=0 -> no snd_valid.
- Upstream stalled, FIFO empty, 3 ticks in RUN -> three snd_valid with snd_data=0, underrun=1, underrun_cnt=3. Next cmd_start clears both.
- FIFO holds 2 words, one request outstanding, cmd_stop -> outstanding word accepted, no new up_req. Next 3 ticks deliver 3 words. snd_end then pulses once, state IDLE, busy=0.
- cmd_start and cmd_stop in the same cycle in IDLE -> nothing happens. Same in RUN -> DRAIN.
- rst_n low for 1 cycle mid-RUN with 3 words queued -> all outputs 0 next cycle, no snd_end. A subsequent tick produces no snd_valid.
